exec_ctrl: RTL and testbench

EXEC_CTRL -- requirements
Module: exec_ctrl

---
 rtl/exec_ctrl_pkg.sv | 68 ++++++
 rtl/exec_ctrl_if.sv | 38 +++
 rtl/exec_ctrl_timer.sv | 40 ++++
 rtl/exec_ctrl.sv | 116 +++++++++++
 tb/tb_exec_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared types and constants for the execution controller.
package exec_ctrl_pkg;

    localparam int unsigned INSTR_W     = 18;
    localparam int unsigned OPR_W       = 4;
    localparam int unsigned REG_W       = 4;
    localparam int unsigned DATA_W      = 64;
    localparam int unsigned RET_W       = 16;
    localparam int unsigned WMODE_W     = 2;
    localparam int unsigned TIMEOUT_DEF = 255;

    // Instruction word field positions
    localparam int unsigned CNST_A_BIT = 17;
    localparam int unsigned CNST_B_BIT = 16;
    localparam int unsigned OPR_LSB    = 12;
    localparam int unsigned RD_LSB     = 8;
    localparam int unsigned RA_LSB     = 4;
    localparam int unsigned RB_LSB     = 0;

    localparam logic [OPR_W-1:0] OPR_NOP = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WAIT,
        ST_WB,
        ST_ERR
    } state_e;

    typedef struct packed {
        logic             cnst_a;
        logic             cnst_b;
        logic [OPR_W-1:0] opr;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
    } instr_t;

    // Registered controller outputs, grouped so they share one register stage
    typedef struct packed {
        logic             ready;
        logic [REG_W-1:0] sel_a;
        logic [REG_W-1:0] sel_b;
        logic             en_rreg;
        logic             cnst_a;
        logic             cnst_b;
        logic [OPR_W-1:0] alu_opr;
        logic             alu_start;
        logic             regwen;
        logic [REG_W-1:0] selwreg;
        logic             busy;
        logic             err;
    } ctrl_out_t;

    // Split a raw instruction word into its fields
    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] w);
        instr_t f;
        f.cnst_a = w[CNST_A_BIT];
        f.cnst_b = w[CNST_B_BIT];
        f.opr    = w[OPR_LSB +: OPR_W];
        f.rd     = w[RD_LSB +: REG_W];
        f.ra     = w[RA_LSB +: REG_W];
        f.rb     = w[RB_LSB +: REG_W];
        return f;
    endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// Instruction, ALU and register-bank signals of the execution controller.
interface exec_ctrl_if;
    import exec_ctrl_pkg::*;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [REG_W-1:0]   seloutA;
    logic [REG_W-1:0]   seloutB;
    logic               enrregA;
    logic               enrregB;
    logic               cnstA;
    logic               cnstB;
    logic [OPR_W-1:0]   alu_opr;
    logic               alu_start;
    logic               alu_done;
    logic [DATA_W-1:0]  alu_result;
    logic               regwen;
    logic [REG_W-1:0]   selwreg;
    logic [WMODE_W-1:0] endwreg;
    logic [DATA_W-1:0]  wdata;
    logic               err_clr;
    logic               busy;
    logic               err;
    logic [RET_W-1:0]   retired;

    modport master (
        output instr_valid, instr, alu_done, alu_result, err_clr,
        input  instr_ready, seloutA, seloutB, enrregA, enrregB, cnstA, cnstB,
               alu_opr, alu_start, regwen, selwreg, endwreg, wdata, busy, err, retired
    );

    modport slave (
        input  instr_valid, instr, alu_done, alu_result, err_clr,
        output instr_ready, seloutA, seloutB, enrregA, enrregB, cnstA, cnstB,
               alu_opr, alu_start, regwen, selwreg, endwreg, wdata, busy, err, retired
    );
endinterface

// File: rtl/exec_ctrl_timer.sv
// WAIT-state cycle counter with a registered expiry flag.
module exec_timer
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q;

    // Count enabled cycles, holding once the limit is reached
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Expired is high during the TIMEOUT-th enabled cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d == CNT_W'(TIMEOUT - 1));
        end
    end

    assign expired_o = expired_q;
endmodule

// File: rtl/exec_ctrl.sv
// Sequences one instruction at a time through register read, ALU and write-back.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input logic        clk,
    input logic        rst,
    exec_ctrl_if.slave ctrl_if
);
    state_e            state_q, state_d;
    instr_t            instr_q, instr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [RET_W-1:0]  retired_q, retired_d;
    ctrl_out_t         out_q, out_d;
    logic              tmr_expired;

    exec_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == ST_EXEC),
        .en_i      (state_q == ST_WAIT),
        .expired_o (tmr_expired)
    );

    // Next state, datapath captures, and outputs decoded from the next state
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        wdata_d   = wdata_q;
        retired_d = retired_q;
        out_d     = '0;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_if.instr_valid) begin
                    instr_d = decode_instr(ctrl_if.instr);
                    if (instr_d.opr == OPR_NOP) begin
                        retired_d = retired_q + RET_W'(1);
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WAIT;
            ST_WAIT: begin
                // Done wins over a simultaneous timeout
                if (ctrl_if.alu_done) begin
                    wdata_d = ctrl_if.alu_result;
                    state_d = ST_WB;
                end else if (tmr_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_WB: begin
                retired_d = retired_q + RET_W'(1);
                state_d   = ST_IDLE;
            end
            ST_ERR: begin
                if (ctrl_if.err_clr) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        out_d.ready     = (state_d == ST_IDLE);
        out_d.en_rreg   = (state_d == ST_READ);
        out_d.sel_a     = out_d.en_rreg ? instr_d.ra : '0;
        out_d.sel_b     = out_d.en_rreg ? instr_d.rb : '0;
        out_d.cnst_a    = out_d.en_rreg & instr_d.cnst_a;
        out_d.cnst_b    = out_d.en_rreg & instr_d.cnst_b;
        out_d.busy      = (state_d inside {ST_READ, ST_EXEC, ST_WAIT, ST_WB});
        out_d.alu_opr   = out_d.busy ? instr_d.opr : '0;
        out_d.alu_start = (state_d == ST_EXEC);
        out_d.regwen    = (state_d == ST_WB);
        out_d.selwreg   = out_d.regwen ? instr_d.rd : '0;
        out_d.err       = (state_d == ST_ERR);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            instr_q      <= '0;
            wdata_q      <= '0;
            retired_q    <= '0;
            out_q        <= '0;
            out_q.ready  <= 1'b1;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            wdata_q      <= wdata_d;
            retired_q    <= retired_d;
            out_q        <= out_d;
        end
    end

    assign ctrl_if.instr_ready = out_q.ready;
    assign ctrl_if.seloutA     = out_q.sel_a;
    assign ctrl_if.seloutB     = out_q.sel_b;
    assign ctrl_if.enrregA     = out_q.en_rreg;
    assign ctrl_if.enrregB     = out_q.en_rreg;
    assign ctrl_if.cnstA       = out_q.cnst_a;
    assign ctrl_if.cnstB       = out_q.cnst_b;
    assign ctrl_if.alu_opr     = out_q.alu_opr;
    assign ctrl_if.alu_start   = out_q.alu_start;
    assign ctrl_if.regwen      = out_q.regwen;
    assign ctrl_if.selwreg     = out_q.selwreg;
    assign ctrl_if.endwreg     = WMODE_W'(0);
    assign ctrl_if.wdata       = wdata_q;
    assign ctrl_if.busy        = out_q.busy;
    assign ctrl_if.err         = out_q.err;
    assign ctrl_if.retired     = retired_q;
endmodule

// File: tb/tb_exec_ctrl.sv
// Scoreboard bench for exec_ctrl: random and directed instructions, ALU responder model.
module tb_exec_ctrl;
    import exec_ctrl_pkg::*;

    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exec_ctrl_if bus ();

    exec_ctrl #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected traffic: READ-phase words, write-backs {opr,rd,result}, ALU response plans
    logic [17:0] rd_q[$];
    logic [71:0] wb_q[$];
    int          plan_d_q[$];
    logic [63:0] plan_r_q[$];

    logic [15:0] exp_ret;
    int          n_start     = 0;
    int          n_wen       = 0;
    int          last_wb_cyc = -10;
    int          acc_cyc     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Offer an instruction and wait for acceptance; update the reference model on the accepting edge
    task automatic issue(input logic [17:0] w, input int d, input logic [63:0] r);
        int n;
        n = 0;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        while (!bus.instr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("accept_timeout", 64'(1), 64'(0));
            bus.instr_valid = 1'b0;
        end else begin
            acc_cyc = cyc;
            @(posedge clk);
            if (w[15:12] == 4'hF) begin
                exp_ret++;
            end else begin
                rd_q.push_back(w);
                plan_d_q.push_back(d);
                plan_r_q.push_back(r);
                if (d != 0) begin
                    wb_q.push_back({w[15:12], w[11:8], r});
                    exp_ret++;
                end
            end
        end
    endtask

    // Drop valid and wait until nothing is in flight
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        while ((bus.busy || wb_q.size() > 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", 64'(1), 64'(0));
    endtask

    // ALU model: answer each alu_start after its planned delay; noise on alu_done otherwise
    initial begin : responder
        int          d;
        int          g;
        logic [63:0] r;
        bus.alu_done   = 1'b0;
        bus.alu_result = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.alu_done = 1'b0;
            end else if (bus.alu_start) begin
                bus.alu_done = 1'b0;
                if (plan_d_q.size() == 0) begin
                    check("unexpected_start", 64'(1), 64'(0));
                end else begin
                    d = plan_d_q.pop_front();
                    r = plan_r_q.pop_front();
                    if (d == 0) begin
                        g = 0;
                        while (bus.busy && !rst && g < 100) begin
                            @(negedge clk);
                            g++;
                        end
                    end else begin
                        repeat (d) @(negedge clk);
                        bus.alu_done   = 1'b1;
                        bus.alu_result = r;
                        @(negedge clk);
                        bus.alu_done   = 1'b0;
                    end
                end
            end else begin
                bus.alu_done   = 1'($urandom_range(0, 1));
                bus.alu_result = {$urandom, $urandom};
            end
        end
    end

    // Monitor: compare every READ and write-back against the scoreboard
    initial begin : monitor
        logic [17:0] w;
        logic [71:0] e;
        logic        prev_read;
        prev_read = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_read = 1'b0;
            end else begin
                if (bus.enrregA) begin
                    if (rd_q.size() == 0) begin
                        check("unexpected_read", 64'(1), 64'(0));
                    end else begin
                        w = rd_q.pop_front();
                        check("read_selA", 64'(bus.seloutA), 64'(w[7:4]));
                        check("read_selB", 64'(bus.seloutB), 64'(w[3:0]));
                        check("read_cnst", 64'({bus.cnstA, bus.cnstB, bus.enrregB}), 64'({w[17:16], 1'b1}));
                        check("read_opr", 64'(bus.alu_opr), 64'(w[15:12]));
                    end
                end
                if (bus.alu_start) begin
                    n_start++;
                    check("start_after_read", 64'(prev_read), 64'(1));
                end
                if (bus.regwen) begin
                    n_wen++;
                    last_wb_cyc = cyc;
                    if (wb_q.size() == 0) begin
                        check("unexpected_regwen", 64'(1), 64'(0));
                    end else begin
                        e = wb_q.pop_front();
                        check("wb_selwreg", 64'(bus.selwreg), 64'(e[67:64]));
                        check("wb_wdata", bus.wdata, e[63:0]);
                        check("wb_mode_opr", 64'({bus.endwreg, bus.alu_opr}), 64'({2'b00, e[71:68]}));
                    end
                end
                if (!bus.busy) check("idle_quiet", 64'({bus.alu_opr, bus.regwen, bus.alu_start}), 64'(0));
                prev_read = bus.enrregA;
            end
        end
    end

    initial begin : watchdog
        #(10 * 90000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed scenarios followed by a randomized stream
    initial begin : stim
        logic [17:0] w1, wa, wb, wn, w;
        logic [63:0] r;
        int          s_start, s_wen, gap;

        w1 = {2'b00, 4'h1, 4'd3, 4'd1, 4'd2};
        wn = {2'b00, 4'hF, 4'd0, 4'd0, 4'd0};
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.err_clr     = 1'b0;
        exp_ret         = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(bus.instr_ready), 64'(1));
        check("rst_flags", 64'({bus.busy, bus.err, bus.alu_start, bus.regwen, bus.enrregA, bus.enrregB}), 64'(0));
        check("rst_sels", 64'({bus.seloutA, bus.seloutB, bus.selwreg, bus.alu_opr, bus.endwreg}), 64'(0));
        check("rst_retired", 64'(bus.retired), 64'(0));
        check("rst_wdata", bus.wdata, 64'(0));
        rst = 1'b0;

        // err_clr outside ERR is ignored
        @(negedge clk) bus.err_clr = 1'b1;
        @(negedge clk) bus.err_clr = 1'b0;
        check("errclr_idle", 64'({bus.instr_ready, bus.err, bus.busy}), 64'(3'b100));

        // Reset asserted during WAIT aborts the instruction
        s_wen = n_wen;
        issue(w1, 0, 64'd0);
        @(negedge clk) bus.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("wait_busy", 64'(bus.busy), 64'(1));
        #1 rst = 1'b1;
        #1;
        check("arst_ready", 64'(bus.instr_ready), 64'(1));
        check("arst_flags", 64'({bus.busy, bus.err, bus.alu_start, bus.regwen, bus.enrregA}), 64'(0));
        check("arst_opr", 64'({bus.alu_opr, bus.seloutA, bus.seloutB}), 64'(0));
        check("arst_retired", 64'(bus.retired), 64'(0));
        @(negedge clk) rst = 1'b0;
        check("arst_no_wen", 64'(n_wen - s_wen), 64'(0));

        // Single instruction, done two cycles after start
        issue(w1, 2, 64'd800);
        wait_idle();
        check("single_retired", 64'(bus.retired), 64'(exp_ret));
        check("single_wen", 64'(n_wen - s_wen), 64'(1));
        check("wdata_hold", bus.wdata, 64'd800);

        // Back-to-back with valid held high
        s_start = n_start;
        wa = {2'b10, 4'h3, 4'd7, 4'd4, 4'd5};
        wb = {2'b01, 4'h9, 4'd12, 4'd14, 4'd0};
        issue(wa, 1, 64'h1234_5678_9abc_def0);
        issue(wb, 3, 64'hffff_0000_aaaa_5555);
        check("b2b_accept_cycle", 64'(acc_cyc), 64'(last_wb_cyc + 1));
        wait_idle();
        check("b2b_retired", 64'(bus.retired), 64'(exp_ret));
        check("b2b_starts", 64'(n_start - s_start), 64'(2));

        // NOP held valid for three cycles
        s_start = n_start;
        s_wen   = n_wen;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = wn;
        repeat (3) @(posedge clk);
        exp_ret = exp_ret + 16'd3;
        wait_idle();
        check("nop_retired", 64'(bus.retired), 64'(exp_ret));
        check("nop_quiet", 64'({n_start - s_start, n_wen - s_wen}), 64'(0));

        // Timeout into ERR, then clear
        s_wen = n_wen;
        issue({2'b00, 4'h2, 4'd6, 4'd8, 4'd9}, 0, 64'd0);
        @(negedge clk) bus.instr_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("err_not_early", 64'({bus.err, bus.busy}), 64'(2'b01));
        @(negedge clk);
        check("err_set", 64'({bus.err, bus.instr_ready, bus.busy, bus.regwen, bus.alu_start}), 64'(5'b10000));
        repeat (3) @(negedge clk);
        check("err_sticky", 64'({bus.err, bus.instr_ready}), 64'(2'b10));
        bus.err_clr = 1'b1;
        @(negedge clk) bus.err_clr = 1'b0;
        check("err_cleared", 64'({bus.err, bus.instr_ready}), 64'(2'b01));
        check("err_no_wen", 64'(n_wen - s_wen), 64'(0));
        check("err_retired", 64'(bus.retired), 64'(exp_ret));

        // Randomized stream with NOPs, varying ALU latency and gaps
        for (int i = 0; i < 80; i++) begin
            w = 18'($urandom);
            if ($urandom_range(0, 4) == 0) w[15:12] = 4'hF;
            else if (w[15:12] == 4'hF) w[15:12] = 4'h0;
            r = {$urandom, $urandom};
            issue(w, int'($urandom_range(1, TO)), r);
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                @(negedge clk) bus.instr_valid = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
        wait_idle();
        check("rand_retired", 64'(bus.retired), 64'(exp_ret));
        check("rand_drained", 64'({rd_q.size(), plan_d_q.size()}), 64'(0));

        // Retired counter wrap
        @(negedge clk) rst = 1'b1;
        #1;
        check("rst2_clear", 64'({bus.retired, 48'(bus.wdata != 0)}), 64'(0));
        @(negedge clk) rst = 1'b0;
        exp_ret = '0;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = wn;
        repeat (65535) @(posedge clk);
        exp_ret = 16'hFFFF;
        wait_idle();
        check("wrap_preload", 64'(bus.retired), 64'(16'hFFFF));
        issue(w1, 1, 64'd42);
        wait_idle();
        check("wrap_zero", 64'(bus.retired), 64'(exp_ret));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
